// File: rtl/mips_bus_pkg.sv
// Shared bus definitions for the MIPS CPU, its Avalon-MM memory slave and the
// instruction/data arbiter in front of that slave.
package mips_bus_pkg;

  localparam int MIPS_ADDR_W = 32;
  localparam int MIPS_DATA_W = 32;

  // Grant source encoding, also the encoding of the round-robin history bit.
  localparam logic GNT_SRC_I = 1'b0;
  localparam logic GNT_SRC_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mips_arb_pick.sv
// Arbitration policy for the instruction/data arbiter.
// Build option MIPS_ARB_ROUND_ROBIN_EN: when defined, ties go to the master
// that did not complete the most recent transaction; when undefined, the data
// master always wins ties and no history input exists.
module mips_arb_pick
  import mips_bus_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
`ifdef MIPS_ARB_ROUND_ROBIN_EN
  input  logic last_gnt,
`endif
  output logic winner
);

  // Choose the winner among the currently requesting masters (1 = data).
  always_comb begin
    winner = GNT_SRC_I;
    if (req_i && req_d) begin
`ifdef MIPS_ARB_ROUND_ROBIN_EN
      winner = ~last_gnt;
`else
      winner = GNT_SRC_D;
`endif
    end else if (req_d) begin
      winner = GNT_SRC_D;
    end
  end

endmodule

// File: rtl/mips_avalon_arbiter.sv
// Two-master (instruction fetch, load/store) to one-slave Avalon-MM arbiter.
// One whole transaction is granted at a time; the granted master's signals
// are forwarded combinationally to the slave and the other master is held
// with waitrequest. An IDLE cycle separates consecutive grants.
// Build option MIPS_ARB_ROUND_ROBIN_EN: defined selects round-robin tie
// breaking using a last-grant register; undefined selects fixed priority
// with the data master winning ties.
module mips_avalon_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W = MIPS_ADDR_W,
  parameter int DATA_W = MIPS_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  // instruction master (read-only)
  input  logic [ADDR_W-1:0]   i_address,
  input  logic                i_read,
  output logic                i_waitrequest,
  output logic [DATA_W-1:0]   i_readdata,
  // data master
  input  logic [ADDR_W-1:0]   d_address,
  input  logic [DATA_W/8-1:0] d_byteenable,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [DATA_W-1:0]   d_writedata,
  output logic                d_waitrequest,
  output logic [DATA_W-1:0]   d_readdata,
  // slave
  output logic [ADDR_W-1:0]   s_address,
  output logic [DATA_W/8-1:0] s_byteenable,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata
);

  arb_state_t state_q, state_d;
  logic       req_i;
  logic       req_d;
  logic       winner;

  assign req_i = i_read;
  assign req_d = d_read | d_write;

`ifdef MIPS_ARB_ROUND_ROBIN_EN
  logic last_gnt_q, last_gnt_d;

  mips_arb_pick u_pick (
    .req_i    (req_i),
    .req_d    (req_d),
    .last_gnt (last_gnt_q),
    .winner   (winner)
  );

  // History of the last completed grant; reset favours I on the first tie.
  always_ff @(posedge clk) begin
    if (reset) last_gnt_q <= GNT_SRC_D;
    else       last_gnt_q <= last_gnt_d;
  end
`else
  mips_arb_pick u_pick (
    .req_i  (req_i),
    .req_d  (req_d),
    .winner (winner)
  );
`endif

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: grant from IDLE, return to IDLE on completion or abandon.
  always_comb begin
    state_d = state_q;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
    last_gnt_d = last_gnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_i || req_d) state_d = (winner == GNT_SRC_D) ? GNT_D : GNT_I;
      end
      GNT_I: begin
        if (!req_i) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
          state_d = IDLE;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
          last_gnt_d = GNT_SRC_I;
`endif
        end
      end
      GNT_D: begin
        if (!req_d) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
          state_d = IDLE;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
          last_gnt_d = GNT_SRC_D;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Forward the granted master to the slave; everyone else is stalled.
  always_comb begin
    s_address     = '0;
    s_byteenable  = '0;
    s_read        = 1'b0;
    s_write       = 1'b0;
    s_writedata   = '0;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    case (state_q)
      GNT_I: begin
        s_address     = i_address;
        s_byteenable  = '1;
        s_read        = i_read;
        i_waitrequest = s_waitrequest;
      end
      GNT_D: begin
        s_address     = d_address;
        s_byteenable  = d_byteenable;
        // a simultaneous read+write request is treated as a write only
        s_read        = d_read & ~d_write;
        s_write       = d_write;
        s_writedata   = d_writedata;
        d_waitrequest = s_waitrequest;
      end
      default: ;
    endcase
  end

  // Read data is shared; only the master with waitrequest low consumes it.
  assign i_readdata = s_readdata;
  assign d_readdata = s_readdata;

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Scoreboard bench for mips_avalon_arbiter: each directed transaction pushes
// its expected slave-side view; a monitor pops and compares on every
// completion (slave request with waitrequest low).
module tb_mips_avalon_arbiter;

  localparam logic [31:0] RD_KEY = 32'h9BC2_0005;

  typedef struct {
    bit          is_d;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stalls;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_address = '0;
  logic        i_read = 1'b0;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic [31:0] d_address = '0;
  logic [3:0]  d_byteenable = '0;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_writedata = '0;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic [31:0] s_address;
  logic [3:0]  s_byteenable;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_writedata;
  logic        s_waitrequest;
  logic [31:0] s_readdata;

  int   stall_cfg = 0;
  int   stall_cnt = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  txn_t exp_q[$];
  txn_t iq[$];
  txn_t dq[$];

  mips_avalon_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .i_address     (i_address),
    .i_read        (i_read),
    .i_waitrequest (i_waitrequest),
    .i_readdata    (i_readdata),
    .d_address     (d_address),
    .d_byteenable  (d_byteenable),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_writedata   (d_writedata),
    .d_waitrequest (d_waitrequest),
    .d_readdata    (d_readdata),
    .s_address     (s_address),
    .s_byteenable  (s_byteenable),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_writedata   (s_writedata),
    .s_waitrequest (s_waitrequest),
    .s_readdata    (s_readdata)
  );

  always #5 clk = ~clk;

  // Slave model: stall_cfg wait cycles per transaction, data = address ^ key.
  assign s_waitrequest = (stall_cnt != 0);
  assign s_readdata    = s_address ^ RD_KEY;

  always @(posedge clk) begin
    if (!(s_read || s_write))  stall_cnt <= stall_cfg;
    else if (stall_cnt != 0)   stall_cnt <= stall_cnt - 1;
    else                       stall_cnt <= stall_cfg;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  function automatic txn_t mk_i(input logic [31:0] addr);
    txn_t t;
    t.is_d = 1'b0; t.rd = 1'b1; t.wr = 1'b0; t.addr = addr; t.be = 4'hF;
    t.wdata = '0; t.rdata = addr ^ RD_KEY; t.stalls = 0;
    return t;
  endfunction

  function automatic txn_t mk_d(input bit rd, input bit wr, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] wdata, input int stalls);
    txn_t t;
    t.is_d = 1'b1; t.rd = rd; t.wr = wr; t.addr = addr; t.be = be;
    t.wdata = wdata; t.rdata = addr ^ RD_KEY; t.stalls = stalls;
    return t;
  endfunction

  task automatic load_i();
    txn_t t;
    if (iq.size() > 0) begin
      t = iq.pop_front();
      i_read = 1'b1; i_address = t.addr;
    end else begin
      i_read = 1'b0; i_address = '0;
    end
  endtask

  task automatic load_d();
    txn_t t;
    if (dq.size() > 0) begin
      t = dq.pop_front();
      d_read = t.rd; d_write = t.wr; d_address = t.addr;
      d_byteenable = t.be; d_writedata = t.wdata;
    end else begin
      d_read = 1'b0; d_write = 1'b0; d_address = '0;
      d_byteenable = '0; d_writedata = '0;
    end
  endtask

  // Both masters issue their queued commands back to back, each holding its
  // request until it sees waitrequest low.
  task automatic run_traffic(input int budget);
    int cyc;
    bit i_fin, d_fin;
    cyc = 0;
    @(posedge clk); #1;
    load_i();
    load_d();
    while ((i_read || d_read || d_write) && cyc < budget) begin
      @(negedge clk);
      i_fin = i_read && !i_waitrequest;
      d_fin = (d_read || d_write) && !d_waitrequest;
      @(posedge clk); #1;
      if (i_fin) load_i();
      if (d_fin) load_d();
      cyc++;
    end
    if (cyc >= budget) begin
      n_checks++;
      $display("FAIL traffic_timeout: %0d cycles used, budget %0d", cyc, budget);
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    end
  endtask

  // Monitor: compares each completion with the scoreboard head.
  initial begin : monitor
    txn_t e;
    int   stall_seen;
    stall_seen = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_seen = 0;
      end else if (s_read || s_write) begin
        if (s_waitrequest) begin
          stall_seen++;
          chk("stall_wreq", {30'd0, i_waitrequest, d_waitrequest}, 32'd3);
          if (exp_q.size() > 0) begin
            chk("stall_addr", s_address, exp_q[0].addr);
            chk("stall_wdata", s_writedata, exp_q[0].wdata);
          end
        end else begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_completion: addr 0x%08h, none expected", s_address);
          end else begin
            e = exp_q.pop_front();
            chk("grant", {30'd0, i_waitrequest, d_waitrequest}, e.is_d ? 32'd2 : 32'd1);
            chk("addr", s_address, e.addr);
            chk("be", {28'd0, s_byteenable}, {28'd0, e.be});
            chk("read", {31'd0, s_read}, {31'd0, e.rd & ~e.wr});
            chk("write", {31'd0, s_write}, {31'd0, e.wr});
            chk("wdata", s_writedata, e.wdata);
            if (e.rd && !e.wr)
              chk("rdata", e.is_d ? d_readdata : i_readdata, e.rdata);
            chk("stalls", stall_seen, e.stalls);
          end
          stall_seen = 0;
        end
      end else begin
        stall_seen = 0;
        chk("idle_wreq", {30'd0, i_waitrequest, d_waitrequest}, 32'd3);
      end
    end
  end

  initial begin : stimulus
    txn_t t;
    logic [3:0] be;
    txn_t ilist[$];
    txn_t dlist[$];

    // reset then idle
    @(posedge clk);
    @(negedge clk);
    chk("rst_s_read", {31'd0, s_read}, 32'd0);
    chk("rst_s_write", {31'd0, s_write}, 32'd0);
    chk("rst_s_addr", s_address, 32'd0);
    chk("rst_wreq", {30'd0, i_waitrequest, d_waitrequest}, 32'd3);
    @(posedge clk); #1;
    reset = 1'b0;

    // lone fetch, zero-wait slave
    @(posedge clk); #1;
    i_read = 1'b1; i_address = 32'hBFC0_0000;
    t = mk_i(32'hBFC0_0000);
    t.rdata = 32'h2402_0005;
    exp_q.push_back(t);
    @(negedge clk);
    chk("fetch_lat_idle", {31'd0, s_read}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fetch_lat_gnt", {31'd0, s_read}, 32'd1);
    @(posedge clk); #1;
    i_read = 1'b0; i_address = '0;
    @(negedge clk);
    chk("fetch_back_idle", {31'd0, s_read}, 32'd0);

    // write held by three slave stall cycles
    stall_cfg = 3;
    t = mk_d(1'b0, 1'b1, 32'h0000_1000, 4'h3, 32'hDEAD_BEEF, 3);
    dq.push_back(t);
    exp_q.push_back(t);
    run_traffic(50);

    // reset while a data write is stalled
    stall_cfg = 5;
    @(posedge clk); #1;
    d_write = 1'b1; d_address = 32'h0000_2000; d_byteenable = 4'hF;
    d_writedata = 32'h1234_5678;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_granted", {31'd0, s_write}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_s_write", {31'd0, s_write}, 32'd0);
    chk("rstmid_wreq", {30'd0, i_waitrequest, d_waitrequest}, 32'd3);
    @(posedge clk); #1;
    reset = 1'b0;
    d_write = 1'b0; d_address = '0; d_byteenable = '0; d_writedata = '0;
    stall_cfg = 0;
    chk("rstmid_no_credit", exp_q.size(), 32'd0);

    // tie right after reset
    iq.push_back(mk_i(32'h0000_0100));
    dq.push_back(mk_d(1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'd0, 0));
`ifdef MIPS_ARB_ROUND_ROBIN_EN
    exp_q.push_back(mk_i(32'h0000_0100));
    exp_q.push_back(mk_d(1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'd0, 0));
`else
    exp_q.push_back(mk_d(1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'd0, 0));
    exp_q.push_back(mk_i(32'h0000_0100));
`endif
    run_traffic(50);

    // both masters continuously requesting, ten transactions each
    for (int k = 0; k < 10; k++) begin
      ilist.push_back(mk_i(32'h0000_0400 + 32'(k * 4)));
      if (k == 5) begin
        dlist.push_back(mk_d(1'b1, 1'b1, 32'h0000_5000 + 32'(k * 4), 4'hF,
                             32'hC0DE_0000 + 32'(k), 0));
      end else if (k % 2 == 0) begin
        dlist.push_back(mk_d(1'b1, 1'b0, 32'h0000_3000 + 32'(k * 4), 4'hF, 32'd0, 0));
      end else begin
        be = 4'(1 << (k % 4));
        dlist.push_back(mk_d(1'b0, 1'b1, 32'h0000_4000 + 32'(k * 4), be,
                             32'hA500_0000 + 32'(k), 0));
      end
    end
    for (int k = 0; k < 10; k++) begin
      iq.push_back(ilist[k]);
      dq.push_back(dlist[k]);
`ifdef MIPS_ARB_ROUND_ROBIN_EN
      exp_q.push_back(ilist[k]);
      exp_q.push_back(dlist[k]);
`endif
    end
`ifndef MIPS_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 10; k++) exp_q.push_back(dlist[k]);
    for (int k = 0; k < 10; k++) exp_q.push_back(ilist[k]);
`endif
    run_traffic(200);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
